// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_arbiter_pkg;

    // Default address/data width used across the core.
    localparam int CONST_WORD_LEN = 32;

    // Owner encoding carried through the tag pipeline.
    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    // Deepest supported memory read latency.
    localparam int RD_LAT_MAX = 4;

    // One in-flight access: whether it exists and who gets the response.
    typedef struct packed {
        logic valid;
        logic owner;
    } tag_t;

    // Which requester (if any) owns the memory port this cycle.
    typedef enum logic [1:0] {
        SEL_NONE = 2'b00,
        SEL_I    = 2'b01,
        SEL_D    = 2'b10
    } sel_e;

    // Round-robin pick. On a conflict the side that lost last time wins;
    // last_d = 1 means D took the previous conflict, so I goes next.
    function automatic sel_e arb_pick(input logic req_i, input logic req_d,
                                      input logic last_d);
        sel_e pick;
        case ({req_i, req_d})
            2'b10:   pick = SEL_I;
            2'b01:   pick = SEL_D;
            2'b11:   pick = last_d ? SEL_I : SEL_D;
            default: pick = SEL_NONE;
        endcase
        return pick;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, data port and memory macro port seen by the arbiter.
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int WORD_LEN = CONST_WORD_LEN
);

    // Instruction-fetch requester
    logic                i_req;
    logic [WORD_LEN-1:0] i_addr;
    logic                i_gnt;
    logic                i_rvalid;
    logic [WORD_LEN-1:0] i_rdata;

    // Data requester
    logic                d_req;
    logic [WORD_LEN-1:0] d_addr;
    logic                d_wen;
    logic [WORD_LEN-1:0] d_wdata;
    logic                d_gnt;
    logic                d_rvalid;
    logic [WORD_LEN-1:0] d_rdata;

    // Memory macro
    logic                m_en;
    logic [WORD_LEN-1:0] m_addr;
    logic                m_wen;
    logic [WORD_LEN-1:0] m_wdata;
    logic [WORD_LEN-1:0] m_rdata;

    // Arbiter side
    modport slave (
        input  i_req, i_addr, d_req, d_addr, d_wen, d_wdata, m_rdata,
        output i_gnt, i_rvalid, i_rdata,
        output d_gnt, d_rvalid, d_rdata,
        output m_en, m_addr, m_wen, m_wdata
    );

    // Core plus memory side
    modport master (
        output i_req, i_addr, d_req, d_addr, d_wen, d_wdata, m_rdata,
        input  i_gnt, i_rvalid, i_rdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  m_en, m_addr, m_wen, m_wdata
    );

endinterface

// File: rtl/mem_arbiter_tag_pipe.sv
// RD_LAT-deep shift register of {valid, owner} tags that tracks which
// requester each outstanding memory access belongs to.
module mem_arbiter_tag_pipe
    import mem_arbiter_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  tag_t tag_in,
    output tag_t tag_out
);

    tag_t stage_r [RD_LAT];

    // Advance every tag one stage per cycle; reset drops all in-flight tags.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < RD_LAT; k++) begin
                stage_r[k] <= '{valid: 1'b0, owner: OWN_I};
            end
        end else begin
            stage_r[0] <= tag_in;
            for (int k = 1; k < RD_LAT; k++) begin
                stage_r[k] <= stage_r[k-1];
            end
        end
    end

    assign tag_out = stage_r[RD_LAT-1];

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous RAM between the fetch and data ports:
// round-robin on conflicts, one access per cycle, responses routed back to
// their owner after the fixed read latency. RD_LAT must be 1..RD_LAT_MAX.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int WORD_LEN = CONST_WORD_LEN,
    parameter int RD_LAT   = 1
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    logic                last_d_r;
    sel_e                sel_s;
    logic                conflict_s;
    logic [WORD_LEN-1:0] m_addr_s;
    logic                m_wen_s;
    logic [WORD_LEN-1:0] m_wdata_s;
    tag_t                tag_in_s;
    tag_t                tag_out_s;
    logic                i_rvalid_s;
    logic                d_rvalid_s;

    assign conflict_s = bus.i_req & bus.d_req;

    // Choose this cycle's winner; nobody is granted while reset is held.
    always_comb begin
        if (rst) begin
            sel_s = SEL_NONE;
        end else begin
            sel_s = arb_pick(bus.i_req, bus.d_req, last_d_r);
        end
    end

    // Record who won the latest conflict; uncontested grants leave it alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_d_r <= 1'b0;
        end else if (conflict_s) begin
            last_d_r <= (sel_s == SEL_D);
        end else begin
            last_d_r <= last_d_r;
        end
    end

    // Steer the winner onto the memory port; fetches never write, idle is all zero.
    always_comb begin
        m_addr_s  = {WORD_LEN{1'b0}};
        m_wen_s   = 1'b0;
        m_wdata_s = {WORD_LEN{1'b0}};
        case (sel_s)
            SEL_I: begin
                m_addr_s = bus.i_addr;
            end
            SEL_D: begin
                m_addr_s  = bus.d_addr;
                m_wen_s   = bus.d_wen;
                m_wdata_s = bus.d_wdata;
            end
            default: begin
                m_addr_s = {WORD_LEN{1'b0}};
            end
        endcase
    end

    // Tag every issued access with its owner so the response can find its way home.
    always_comb begin
        tag_in_s.valid = (sel_s != SEL_NONE);
        if (sel_s == SEL_D) begin
            tag_in_s.owner = OWN_D;
        end else begin
            tag_in_s.owner = OWN_I;
        end
    end

    mem_arbiter_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .tag_in  (tag_in_s),
        .tag_out (tag_out_s)
    );

    // Decode the oldest tag into a single response strobe for its owner.
    always_comb begin
        i_rvalid_s = 1'b0;
        d_rvalid_s = 1'b0;
        if (rst) begin
            i_rvalid_s = 1'b0;
            d_rvalid_s = 1'b0;
        end else if (tag_out_s.valid) begin
            if (tag_out_s.owner == OWN_D) begin
                d_rvalid_s = 1'b1;
            end else begin
                i_rvalid_s = 1'b1;
            end
        end else begin
            i_rvalid_s = 1'b0;
            d_rvalid_s = 1'b0;
        end
    end

    assign bus.i_gnt    = (sel_s == SEL_I);
    assign bus.d_gnt    = (sel_s == SEL_D);
    assign bus.m_en     = (sel_s != SEL_NONE);
    assign bus.m_addr   = m_addr_s;
    assign bus.m_wen    = m_wen_s;
    assign bus.m_wdata  = m_wdata_s;
    assign bus.i_rvalid = i_rvalid_s;
    assign bus.d_rvalid = d_rvalid_s;
    assign bus.i_rdata  = i_rvalid_s ? bus.m_rdata : {WORD_LEN{1'b0}};
    assign bus.d_rdata  = d_rvalid_s ? bus.m_rdata : {WORD_LEN{1'b0}};

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: three instances (RD_LAT 1, 2, 3) share one stimulus
// stream, each with its own RAM model, checked against a grant-log reference.
`timescale 1ns/1ps
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int NL = 3;
    localparam int WL = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          i_req, d_req, d_wen;
    logic [WL-1:0] i_addr, d_addr, d_wdata;

    logic          o_i_gnt [NL], o_d_gnt [NL], o_i_rv [NL], o_d_rv [NL];
    logic          o_m_en [NL], o_m_wen [NL];
    logic [WL-1:0] o_i_rd [NL], o_d_rd [NL], o_m_addr [NL], o_m_wdata [NL];

    // Power-up RAM contents; word 4 (address 0x10) holds the fetch test pattern.
    function automatic logic [31:0] init_word(input logic [7:0] idx);
        if (idx == 8'd4) return 32'h00A0_0093;
        return 32'h5A00_0000 | {16'h0000, idx, idx};
    endfunction

    for (genvar g = 0; g < NL; g++) begin : g_lat
        localparam int LAT = g + 1;
        mem_arbiter_if #(.WORD_LEN(WL)) bus ();
        bit   [31:0] mem [256];
        bit          wr  [256];
        logic [31:0] rpipe [LAT];
        logic [7:0]  idx;

        assign bus.i_req   = i_req;
        assign bus.i_addr  = i_addr;
        assign bus.d_req   = d_req;
        assign bus.d_addr  = d_addr;
        assign bus.d_wen   = d_wen;
        assign bus.d_wdata = d_wdata;
        assign bus.m_rdata = rpipe[LAT-1];
        assign idx         = bus.m_addr[9:2];

        mem_arbiter #(.WORD_LEN(WL), .RD_LAT(LAT)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        // Single-port RAM, read-first, data out LAT cycles after m_en.
        always @(posedge clk) begin
            if (bus.m_en) begin
                rpipe[0] <= wr[idx] ? mem[idx] : init_word(idx);
                if (bus.m_wen) begin
                    mem[idx] <= bus.m_wdata;
                    wr[idx]  <= 1'b1;
                end
            end else begin
                rpipe[0] <= 32'hDEAD_0000;
            end
            for (int k = 1; k < LAT; k++) rpipe[k] <= rpipe[k-1];
        end

        assign o_i_gnt[g]   = bus.i_gnt;
        assign o_d_gnt[g]   = bus.d_gnt;
        assign o_i_rv[g]    = bus.i_rvalid;
        assign o_d_rv[g]    = bus.d_rvalid;
        assign o_i_rd[g]    = bus.i_rdata;
        assign o_d_rd[g]    = bus.d_rdata;
        assign o_m_en[g]    = bus.m_en;
        assign o_m_wen[g]   = bus.m_wen;
        assign o_m_addr[g]  = bus.m_addr;
        assign o_m_wdata[g] = bus.m_wdata;
    end

    // ---------------- reference model ----------------
    typedef struct packed {
        int          cyc;
        logic        owner;
        logic        store;
        logic [31:0] data;
    } resp_t;

    resp_t       q [$];
    bit   [31:0] rmem [256];
    bit          rwr  [256];
    bit          m_last_d;
    int          cyc;
    int          n_checks, n_fail;

    bit          e_i_gnt, e_d_gnt, e_m_en, e_m_wen;
    logic [31:0] e_m_addr, e_m_wdata;
    bit          e_i_rv [NL], e_d_rv [NL], e_store [NL];
    logic [31:0] e_i_rd [NL], e_d_rd [NL];

    // Expected outputs for the current cycle, then log this cycle's grant.
    task automatic model_cycle();
        bit          gi, gd;
        logic [7:0]  ix;
        resp_t       r;
        gi = 1'b0;
        gd = 1'b0;
        for (int g = 0; g < NL; g++) begin
            e_i_rv[g] = 1'b0; e_d_rv[g] = 1'b0; e_store[g] = 1'b0;
            e_i_rd[g] = 32'h0; e_d_rd[g] = 32'h0;
        end
        if (rst) begin
            q.delete();
            m_last_d = 1'b0;
        end else begin
            foreach (q[n]) begin
                for (int g = 0; g < NL; g++) begin
                    if (q[n].cyc == cyc - (g + 1)) begin
                        if (q[n].owner) begin
                            e_d_rv[g] = 1'b1; e_d_rd[g] = q[n].data;
                        end else begin
                            e_i_rv[g] = 1'b1; e_i_rd[g] = q[n].data;
                        end
                        e_store[g] = q[n].store;
                    end
                end
            end
            if (i_req && d_req) begin
                gd = !m_last_d;
                gi = m_last_d;
                m_last_d = gd;
            end else begin
                gi = i_req;
                gd = d_req;
            end
        end
        e_i_gnt   = gi;
        e_d_gnt   = gd;
        e_m_en    = gi | gd;
        e_m_addr  = gi ? i_addr : (gd ? d_addr : 32'h0);
        e_m_wen   = gd & d_wen;
        e_m_wdata = gd ? d_wdata : 32'h0;
        if (gi) begin
            ix = i_addr[9:2];
            r.cyc = cyc; r.owner = 1'b0; r.store = 1'b0;
            r.data = rwr[ix] ? rmem[ix] : init_word(ix);
            q.push_back(r);
        end
        if (gd) begin
            ix = d_addr[9:2];
            r.cyc = cyc; r.owner = 1'b1; r.store = d_wen;
            r.data = d_wen ? 32'h0 : (rwr[ix] ? rmem[ix] : init_word(ix));
            q.push_back(r);
            if (d_wen) begin
                rmem[ix] = d_wdata;
                rwr[ix]  = 1'b1;
            end
        end
        while (q.size() > 0 && q[0].cyc < cyc - NL) void'(q.pop_front());
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_inputs();
        i_req = 1'b0; d_req = 1'b0; d_wen = 1'b0;
        i_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        i_req = 1'b1; d_req = 1'b1; d_wen = 1'b1;
        i_addr = 32'h44; d_addr = 32'h88; d_wdata = 32'h1234_5678;
        for (int c = 0; c < 5; c++) begin
            if (c == 3) begin
                rst = 1'b0;
                idle_inputs();
            end
            @(negedge clk);
            model_cycle();
            for (int g = 0; g < NL; g++) begin
                n_checks++;
                if ({o_i_gnt[g], o_d_gnt[g], o_m_en[g], o_m_wen[g], o_i_rv[g], o_d_rv[g]} !== 6'b0) begin
                    n_fail++;
                    $display("FAIL reset_ctrl lat=%0d c=%0d got=%b required=000000", g + 1, c,
                             {o_i_gnt[g], o_d_gnt[g], o_m_en[g], o_m_wen[g], o_i_rv[g], o_d_rv[g]});
                end
                n_checks++;
                if ({o_m_addr[g], o_m_wdata[g], o_i_rd[g], o_d_rd[g]} !== 128'h0) begin
                    n_fail++;
                    $display("FAIL reset_data lat=%0d c=%0d addr=%h wdata=%h irdata=%h drdata=%h required=0",
                             g + 1, c, o_m_addr[g], o_m_wdata[g], o_i_rd[g], o_d_rd[g]);
                end
            end
            tick();
        end
    endtask

    task automatic test_single_fetch();
        i_req = 1'b1; i_addr = 32'h0000_0010;
        @(negedge clk);
        model_cycle();
        n_checks++;
        if (o_i_gnt[0] !== 1'b1 || o_d_gnt[0] !== 1'b0 || o_m_addr[0] !== 32'h10 || o_m_wen[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_grant got gnt=%b/%b addr=%h wen=%b required 1/0 00000010 0",
                     o_i_gnt[0], o_d_gnt[0], o_m_addr[0], o_m_wen[0]);
        end
        tick();
        idle_inputs();
        @(negedge clk);
        model_cycle();
        n_checks++;
        if (o_i_rv[0] !== 1'b1 || o_i_rd[0] !== 32'h00A0_0093 || o_d_rv[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_resp got rvalid=%b rdata=%h d_rvalid=%b required 1 00a00093 0",
                     o_i_rv[0], o_i_rd[0], o_d_rv[0]);
        end
        tick();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            model_cycle();
            tick();
        end
    endtask

    task automatic test_conflict();
        bit exp_d;
        for (int c = 0; c < 8; c++) begin
            if (c < 4) begin
                i_req = 1'b1; i_addr = 32'h40; d_req = 1'b1; d_addr = 32'h80; d_wen = 1'b0;
            end else begin
                idle_inputs();
            end
            @(negedge clk);
            model_cycle();
            exp_d = (c % 2 == 0);
            for (int g = 0; g < NL; g++) begin
                if (c < 4) begin
                    n_checks++;
                    if (o_d_gnt[g] !== exp_d || o_i_gnt[g] !== !exp_d ||
                        o_m_addr[g] !== (exp_d ? 32'h80 : 32'h40)) begin
                        n_fail++;
                        $display("FAIL conflict_order lat=%0d c=%0d got d/i=%b%b addr=%h required d=%b",
                                 g + 1, c, o_d_gnt[g], o_i_gnt[g], o_m_addr[g], exp_d);
                    end
                end
                n_checks++;
                if (o_i_rv[g] !== e_i_rv[g] || o_d_rv[g] !== e_d_rv[g] ||
                    o_i_rd[g] !== e_i_rd[g] || o_d_rd[g] !== e_d_rd[g]) begin
                    n_fail++;
                    $display("FAIL conflict_resp lat=%0d c=%0d got rv=%b%b rd=%h/%h required rv=%b%b rd=%h/%h",
                             g + 1, c, o_i_rv[g], o_d_rv[g], o_i_rd[g], o_d_rd[g],
                             e_i_rv[g], e_d_rv[g], e_i_rd[g], e_d_rd[g]);
                end
            end
            tick();
        end
    endtask

    task automatic test_store_load();
        for (int rel = 0; rel < 6; rel++) begin
            idle_inputs();
            if (rel < 2) begin
                d_req = 1'b1; d_addr = 32'h100;
                d_wen = (rel == 0); d_wdata = (rel == 0) ? 32'hDEAD_BEEF : 32'h0;
            end
            @(negedge clk);
            model_cycle();
            for (int g = 0; g < NL; g++) begin
                if (rel < 2) begin
                    n_checks++;
                    if (o_d_gnt[g] !== 1'b1 || o_m_wen[g] !== (rel == 0)) begin
                        n_fail++;
                        $display("FAIL st_ld_grant lat=%0d rel=%0d got gnt=%b wen=%b", g + 1, rel,
                                 o_d_gnt[g], o_m_wen[g]);
                    end
                end
                n_checks++;
                if (o_d_rv[g] !== (rel == g + 1 || rel == g + 2) || o_i_rv[g] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL st_ld_rvalid lat=%0d rel=%0d got d=%b i=%b required d=%b i=0", g + 1, rel,
                             o_d_rv[g], o_i_rv[g], (rel == g + 1 || rel == g + 2));
                end
                if (rel == g + 2) begin
                    n_checks++;
                    if (o_d_rd[g] !== 32'hDEAD_BEEF) begin
                        n_fail++;
                        $display("FAIL st_ld_data lat=%0d got=%h required=deadbeef", g + 1, o_d_rd[g]);
                    end
                end
            end
            tick();
        end
    endtask

    task automatic test_random_stream();
        bit          keep_i, keep_d;
        logic [31:0] a;
        for (int n = 0; n < 400; n++) begin
            keep_i = i_req && !e_i_gnt;
            keep_d = d_req && !e_d_gnt;
            if (!keep_i) begin
                i_req = (n < 100) ? 1'b1 : ($urandom_range(0, 9) < 7);
                a = $urandom_range(0, 63);
                i_addr = a << 2;
            end
            if (!keep_d) begin
                d_req = (n < 100) ? 1'b1 : ($urandom_range(0, 9) < 7);
                d_wen = (n < 100) ? 1'b0 : ($urandom_range(0, 9) < 3);
                a = $urandom_range(0, 63);
                d_addr = a << 2;
                d_wdata = $urandom();
            end
            @(negedge clk);
            model_cycle();
            for (int g = 0; g < NL; g++) begin
                n_checks++;
                if (o_i_gnt[g] !== e_i_gnt || o_d_gnt[g] !== e_d_gnt || o_m_en[g] !== e_m_en) begin
                    n_fail++;
                    $display("FAIL rand_gnt lat=%0d n=%0d got i/d/en=%b%b%b required %b%b%b", g + 1, n,
                             o_i_gnt[g], o_d_gnt[g], o_m_en[g], e_i_gnt, e_d_gnt, e_m_en);
                end
                n_checks++;
                if (o_m_addr[g] !== e_m_addr || o_m_wen[g] !== e_m_wen || o_m_wdata[g] !== e_m_wdata) begin
                    n_fail++;
                    $display("FAIL rand_mem lat=%0d n=%0d got %h/%b/%h required %h/%b/%h", g + 1, n,
                             o_m_addr[g], o_m_wen[g], o_m_wdata[g], e_m_addr, e_m_wen, e_m_wdata);
                end
                n_checks++;
                if (o_i_rv[g] !== e_i_rv[g] || o_d_rv[g] !== e_d_rv[g] || o_i_rd[g] !== e_i_rd[g]) begin
                    n_fail++;
                    $display("FAIL rand_resp lat=%0d n=%0d got rv=%b%b ird=%h required rv=%b%b ird=%h", g + 1, n,
                             o_i_rv[g], o_d_rv[g], o_i_rd[g], e_i_rv[g], e_d_rv[g], e_i_rd[g]);
                end
                if (!e_store[g]) begin
                    n_checks++;
                    if (o_d_rd[g] !== e_d_rd[g]) begin
                        n_fail++;
                        $display("FAIL rand_drdata lat=%0d n=%0d got=%h required=%h", g + 1, n,
                                 o_d_rd[g], e_d_rd[g]);
                    end
                end
            end
            tick();
        end
    endtask

    task automatic test_reset_midflight();
        for (int k = 0; k < 2; k++) begin
            if (m_last_d) break;
            i_req = 1'b1; i_addr = 32'h8; d_req = 1'b1; d_addr = 32'hC; d_wen = 1'b0;
            @(negedge clk);
            model_cycle();
            tick();
        end
        idle_inputs();
        d_req = 1'b1; d_addr = 32'h20;
        @(negedge clk);
        model_cycle();
        n_checks++;
        if (o_d_gnt[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_grant got=%b required=1", o_d_gnt[1]);
        end
        tick();
        idle_inputs();
        for (int c = 0; c < 7; c++) begin
            rst = (c == 0);
            @(negedge clk);
            model_cycle();
            for (int g = 0; g < NL; g++) begin
                n_checks++;
                if (o_i_rv[g] !== 1'b0 || o_d_rv[g] !== 1'b0 || o_i_rd[g] !== 32'h0 || o_d_rd[g] !== 32'h0) begin
                    n_fail++;
                    $display("FAIL midrst_drop lat=%0d c=%0d got rv=%b%b rd=%h/%h required none", g + 1, c,
                             o_i_rv[g], o_d_rv[g], o_i_rd[g], o_d_rd[g]);
                end
            end
            tick();
        end
        i_req = 1'b1; i_addr = 32'h8; d_req = 1'b1; d_addr = 32'hC; d_wen = 1'b0;
        @(negedge clk);
        model_cycle();
        for (int g = 0; g < NL; g++) begin
            n_checks++;
            if (o_d_gnt[g] !== 1'b1 || o_i_gnt[g] !== 1'b0) begin
                n_fail++;
                $display("FAIL midrst_ptr lat=%0d got d/i=%b%b required 10", g + 1, o_d_gnt[g], o_i_gnt[g]);
            end
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_idle();
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            model_cycle();
            if (c >= 4) begin
                for (int g = 0; g < NL; g++) begin
                    n_checks++;
                    if ({o_m_en[g], o_m_wen[g], o_i_gnt[g], o_d_gnt[g], o_i_rv[g], o_d_rv[g]} !== 6'b0) begin
                        n_fail++;
                        $display("FAIL idle lat=%0d c=%0d got=%b required=000000", g + 1, c,
                                 {o_m_en[g], o_m_wen[g], o_i_gnt[g], o_d_gnt[g], o_i_rv[g], o_d_rv[g]});
                    end
                end
            end
            tick();
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        m_last_d = 1'b0;
        rst      = 1'b1;
        idle_inputs();
        test_reset();
        test_single_fetch();
        test_conflict();
        test_store_load();
        test_random_stream();
        test_reset_midflight();
        test_idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares one single-port synchronous RAM between the core's instruction-fetch port and its data port, so instruction and data memory can be one array. It sits between `core` (ImemPort `addr_i`/`inst`, DmemPort `addr_d`/`rdata`/`wen`/`wdata`) and the memory macro. It does three things:
- resolves same-cycle conflicts round-robin;
- issues at most one memory access per cycle;
- routes each read response back to its owner after the fixed memory latency, using an owner-tag pipeline.

## Interface
- `WORD_LEN`, 32: address and data width.
- `RD_LAT`, 1: memory read latency in cycles, from `m_en` to valid `m_rdata`. Legal range 1..4.

- `clk`  in  1  the single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `i_req`  in  1  fetch request; held until granted.
- `i_addr`  in  WORD_LEN  fetch address; stable while `i_req` is high.
- `i_gnt`  out  1  fetch request accepted this cycle.
- `i_rvalid`  out  1  fetch response valid; one pulse per accepted fetch.
- `i_rdata`  out  WORD_LEN  fetch data; valid when `i_rvalid` is high.
- `d_req`  in  1  data request; held until granted.
- `d_addr`  in  WORD_LEN  data address.
- `d_wen`  in  1  1 = store, 0 = load.
- `d_wdata`  in  WORD_LEN  store data.
- `d_gnt`  out  1  data request accepted this cycle.
- `d_rvalid`  out  1  data response; one pulse per accepted load or store.
- `d_rdata`  out  WORD_LEN  load data; don't-care for stores.
- `m_en`  out  1  memory access strobe.
- `m_addr`  out  WORD_LEN  memory address.
- `m_wen`  out  1  memory write enable.
- `m_wdata`  out  WORD_LEN  memory write data.
- `m_rdata`  in  WORD_LEN  memory read data, returned RD_LAT cycles after `m_en`.

## Operation
**Arbitration** (combinational in the request cycle):
- Only `i_req` high: grant I.
- Only `d_req` high: grant D.
- Both high: grant the requester that did not win the last conflict. 1-bit pointer `last_d`, reset 0, so D wins the first conflict.
- `last_d` updates only on a conflict cycle: `last_d` ← 1 if D was granted, 0 if I was granted. Uncontested grants leave it unchanged.

**Memory drive:**
- `m_en = i_gnt | d_gnt`.
- `m_addr`, `m_wen`, `m_wdata` are muxed from the granted requester.
- For I grants, `m_wen` = 0 and `m_wdata` = 0.
- When there is no grant, `m_addr`, `m_wen`, `m_wdata` are 0.
- Requester handshake: a request transfers in any cycle where req && gnt. Requester inputs may change freely after that cycle.

**Tag pipeline:**
- RD_LAT stages, each holding {valid, owner}; owner 0 = I, 1 = D.
- Stage 0 loads {`m_en`, `d_gnt`} each cycle; stages shift every cycle with no stall.
- At the last stage: `i_rvalid` = valid && owner==I; `d_rvalid` = valid && owner==D.
- `i_rdata` and `d_rdata` are both `m_rdata` gated by their own rvalid (0 otherwise).
- Store responses follow the same path, so a store completes exactly RD_LAT cycles after its grant.
- Responses return in grant order. The block has no outstanding limit; throughput is one access per cycle.

## Timing
- Grant latency is 0 cycles: gnt is asserted combinationally in the same cycle as req when the requester wins.
- Response latency is exactly RD_LAT cycles after gnt.
- A back-to-back stream from one requester gets one grant per cycle.
- On conflict, the loser's gnt is low. It wins the next cycle if it holds req and the winner also requests again.
- Simultaneous response and new grant: independent, both occur in the same cycle.

**Reset** (`rst` sampled high at a rising edge):
- `last_d` ← 0; all tag valids ← 0.
- In-flight responses are dropped: no rvalid appears after reset, even though memory may still return data.
- While `rst` is high: all gnt, rvalid, `m_en`, `m_wen` outputs are forced 0, and `m_addr`, `m_wdata`, rdata outputs are 0.
- After reset, all outputs are 0 until the first req.

## Structure
- Shared package `mem_arb_pkg.vh`:
  - owner encodings `OWN_I` = 1'b0, `OWN_D` = 1'b1;
  - `RD_LAT_MAX` = 4.
- `WORD_LEN` comes from the existing `consts.vh`.
- One sub-module: `tag_pipe`, a parameterised RD_LAT-deep shift register of {valid, owner} with synchronous clear.
- Arbitration and muxing stay in `mem_arbiter`.

## Test plan
- **Single fetch:** RD_LAT=1, `i_req` with `i_addr`=0x00000010, memory holds 0x00A00093 at that address. Required: `i_gnt` the same cycle; `i_rvalid`=1 with `i_rdata`=0x00A00093 one cycle later; `d_rvalid` stays 0.
- **Conflict alternation:** both req held 4 cycles, all loads. Required grant order D, I, D, I; `m_addr` alternates accordingly; responses return in the same order.
- **Store then load, same address:** `d_wen`=1, `d_addr`=0x100, `d_wdata`=0xDEADBEEF, then a load of 0x100 the next cycle. Required: `d_rvalid` for the store, then `d_rdata`=0xDEADBEEF.
- **Latency sweep:** RD_LAT=3, alternating I/D loads every cycle. Required: each rvalid exactly 3 cycles after its gnt, with the correct owner.
- **Reset mid-flight:** RD_LAT=2, grant a load, assert `rst` the next cycle for 1 cycle. Required: no rvalid ever appears for that load; `last_d`=0, so D wins the next conflict.
- **Idle:** no req for 10 cycles. Required: `m_en`, `m_wen` and both gnt/rvalid pairs stay 0.
